// File: rtl/bdd_walk_ctrl.sv
// Walk sequencer for the BDD classifier: arbitrates host table loads against queries and
// steps node/edge RAM reads from the root to a leaf, one query in flight.
module bdd_walk_ctrl #(
    parameter int unsigned RAM1_DATA_WIDTH = 34,
    parameter int unsigned RAM2_DATA_WIDTH = 18,
    parameter int unsigned ADDR_WIDTH      = 4,
    parameter int unsigned ROOT            = 0,
    parameter int unsigned MAX_HOPS        = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       we1,
    input  logic                       we2,
    input  logic [ADDR_WIDTH-1:0]      in_addr,
    input  logic [RAM1_DATA_WIDTH-1:0] ram1_data_in,
    input  logic [RAM2_DATA_WIDTH-1:0] ram2_data_in,
    output logic                       ld_ready,
    output logic                       ld_drop,
    input  logic                       q_valid,
    input  logic [23:0]                q_attr,
    output logic                       q_ready,
    output logic                       r_valid,
    input  logic                       r_ready,
    output logic [7:0]                 r_class,
    output logic                       r_err,
    output logic [ADDR_WIDTH-1:0]      ram_addr,
    output logic                       ram1_we,
    output logic                       ram2_we,
    output logic [RAM1_DATA_WIDTH-1:0] ram1_wdata,
    output logic [RAM2_DATA_WIDTH-1:0] ram2_wdata,
    input  logic [RAM1_DATA_WIDTH-1:0] ram1_rdata,
    input  logic [RAM2_DATA_WIDTH-1:0] ram2_rdata
);

    typedef enum logic [1:0] {StIdle, StWait, StEval, StDone} state_e;

    state_e                state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            hop;
    logic [23:0]           attr;

    logic        idle;
    logic        host_wr;
    logic [15:0] prod0, prod1, prod2;
    logic [17:0] dot;
    logic        taken;
    logic [8:0]  br;
    logic        addr_ovf;
    logic        hop_last;

    assign idle    = (state == StIdle);
    assign host_wr = we1 | we2;

    assign ld_ready   = idle;
    assign q_ready    = idle & ~host_wr;
    assign ram1_we    = idle & we1;
    assign ram2_we    = idle & we2;
    // Host writes steal the shared address only while idle; otherwise the walk owns it.
    assign ram_addr   = (idle && host_wr) ? in_addr : addr_q;
    assign ram1_wdata = ram1_data_in;
    assign ram2_wdata = ram2_data_in;
    assign r_valid    = (state == StDone);

    assign prod0 = 16'(ram1_rdata[33:26]) * 16'(attr[23:16]);
    assign prod1 = 16'(ram1_rdata[25:18]) * 16'(attr[15:8]);
    assign prod2 = 16'(ram1_rdata[17:10]) * 16'(attr[7:0]);
    assign dot   = 18'(prod0) + 18'(prod1) + 18'(prod2);
    assign taken = (dot >= {8'b0, ram1_rdata[9:0]});
    assign br    = taken ? ram2_rdata[17:9] : ram2_rdata[8:0];

    assign addr_ovf = ((br[7:0] >> ADDR_WIDTH) != 8'd0);
    assign hop_last = ((9'(hop) + 9'd1) == 9'(MAX_HOPS));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= StIdle;
            addr_q  <= '0;
            hop     <= '0;
            attr    <= '0;
            r_class <= '0;
            r_err   <= 1'b0;
            ld_drop <= 1'b0;
        end else begin
            if (!idle && host_wr) begin
                ld_drop <= 1'b1;
            end
            case (state)
                StIdle: begin
                    if (q_valid && q_ready) begin
                        attr   <= q_attr;
                        addr_q <= ADDR_WIDTH'(ROOT);
                        hop    <= '0;
                        state  <= StWait;
                    end
                end
                StWait: state <= StEval;
                StEval: begin
                    if (br[8]) begin
                        r_class <= br[7:0];
                        r_err   <= 1'b0;
                        state   <= StDone;
                    end else if (addr_ovf || hop_last) begin
                        r_class <= 8'hFF;
                        r_err   <= 1'b1;
                        state   <= StDone;
                    end else begin
                        addr_q <= br[ADDR_WIDTH-1:0];
                        hop    <= hop + 8'd1;
                        state  <= StWait;
                    end
                end
                StDone: begin
                    if (r_ready) begin
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
